wb_slave_regfile: RTL

- Wishbone B4 classic single-cycle slave; the downstream consumer of the team's Wishbone master cycles.
- Decodes cyc/stb requests into a bank of NUM_REGS registers of DATA_W bits, with byte-lane writes.
- Generates a one-cycle ack_o after a programmable number of wait states.
- Serves as the default bus target for master bring-up and for interconnect tests.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_regfile_mem.sv | 52 +++++
 rtl/wb_slave_regfile.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone slave types: FSM state encoding, default data width, byte-lane mask helper.
package wb_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_MAX_DATA_W = 256;
  localparam int WB_MAX_SEL_W  = WB_MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Expands each sel bit into a full byte of ones; callers truncate to their bus width.
  function automatic logic [WB_MAX_DATA_W-1:0] sel_to_mask(input logic [WB_MAX_SEL_W-1:0] sel);
    logic [WB_MAX_DATA_W-1:0] m;
    m = '0;
    for (int k = 0; k < WB_MAX_SEL_W; k++) begin
      m[k*8 +: 8] = {8{sel[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_regfile_mem.sv
// Register bank with a byte-enable write port and a registered read port; read data
// appears the cycle after rd_en_i and is 0 on every other cycle, no backpressure.
module wb_regfile_mem
  import wb_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_adr_i,
  input  logic [DATA_W-1:0]   wr_dat_i,
  input  logic [DATA_W/8-1:0] wr_sel_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_adr_i,
  output logic [DATA_W-1:0]   rd_dat_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rd_dat_q;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_mask;

  assign wr_mask = DATA_W'(sel_to_mask(WB_MAX_SEL_W'(wr_sel_i)));

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_adr_i == ADDR_W'(i)) rd_word = regs_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_adr_i == ADDR_W'(i)) regs_q[i] <= (regs_q[i] & ~wr_mask) | (wr_dat_i & wr_mask);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rd_dat_q <= '0;
    else        rd_dat_q <= rd_en_i ? rd_word : '0;
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 classic slave over a register bank; ack_o (err_o for out-of-range when WB_SLAVE_ERR_EN
// is defined) pulses WAIT_STATES+1 cycles after acceptance; never stalls, one transfer per WAIT_STATES+2 cycles.
module wb_slave_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int ADDR_W      = 4,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   adr_i,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic [DATA_W/8-1:0] sel_i,
  output logic [DATA_W-1:0]   dat_o,
  output logic                ack_o,
  output logic                err_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  wb_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              capture;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_dat;
  logic [SEL_W-1:0]  req_sel;
  logic              req_we;
  logic              enter_resp;
  logic              in_range;
  logic              ack_d, ack_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A dropped cycle beats an expiring counter: the transfer is abandoned.
        if (!cyc_i)            state_d = IDLE;
        else if (cnt_q == 4'd0) state_d = RESP;
        else                   cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      if (capture) begin
        adr_q <= adr_i;
        dat_q <= dat_i;
        sel_q <= sel_i;
        we_q  <= we_i;
      end
    end
  end

  // With zero wait states the accepting edge is also the commit edge, so the live bus is used.
  assign req_adr    = (state_q == IDLE) ? adr_i : adr_q;
  assign req_dat    = (state_q == IDLE) ? dat_i : dat_q;
  assign req_sel    = (state_q == IDLE) ? sel_i : sel_q;
  assign req_we     = (state_q == IDLE) ? we_i  : we_q;
  assign enter_resp = (state_d == RESP);
  assign in_range   = ({1'b0, req_adr} < NUM_REGS_L);

`ifdef WB_SLAVE_ERR_EN
  logic err_d, err_q;

  assign ack_d = enter_resp & in_range;
  assign err_d = enter_resp & ~in_range;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign ack_d = enter_resp;
  assign err_o = 1'b0;
`endif

  assign ack_o = ack_q;

  wb_regfile_mem #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_mem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (enter_resp & req_we & in_range),
    .wr_adr_i (req_adr),
    .wr_dat_i (req_dat),
    .wr_sel_i (req_sel),
    .rd_en_i  (enter_resp & ~req_we & in_range),
    .rd_adr_i (req_adr),
    .rd_dat_o (dat_o)
  );

endmodule
